input_debouncer: RTL and testbench

//   Conditions a raw asynchronous level input (pushbutton, external strobe) into a

---
 rtl/input_debouncer.sv | 152 +++++++++++++++
 tb/tb_input_debouncer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// ---------------------------------------------------------------------------
// input_debouncer
//
// Turns a raw asynchronous level (pushbutton, external strobe) into a clean,
// clk-synchronous level suitable for a downstream rising-edge pulse detector.
//
//   1. din is brought into the clk domain through a SYNC_STAGES-deep flop chain.
//   2. A two-state filter (STABLE / CHECK) only moves dout to the synchronised
//      value after it has disagreed with dout for DEBOUNCE_CYCLES consecutive
//      enabled samples.
//   3. A candidate transition that collapses before it is committed raises a
//      one-cycle glitch pulse.
//
// Parameters
//   SYNC_STAGES      synchroniser depth (>= 2)
//   DEBOUNCE_CYCLES  consecutive differing samples needed to commit (>= 1)
//   RESET_LEVEL      value of the synchroniser flops and dout while in reset
//
// Ports
//   clk     in   single clock, all logic on posedge
//   resetn  in   asynchronous active-low reset (release synchronous to clk)
//   en      in   1: filtering active; 0: filter frozen in STABLE, dout held
//   din     in   raw asynchronous level
//   dout    out  debounced, synchronised level (registered)
//   busy    out  1 while a candidate transition is being counted (CHECK)
//   glitch  out  registered one-cycle pulse when a candidate is aborted
//
// busy is a direct decode of the registered FSM state, so it doubles as the
// state observation point for checkers (busy == 1 <=> state == CHECK).
// ---------------------------------------------------------------------------
module input_debouncer #(
    parameter int   SYNC_STAGES     = 2,
    parameter int   DEBOUNCE_CYCLES = 16,
    parameter logic RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic en,
    input  logic din,
    output logic dout,
    output logic busy,
    output logic glitch
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
    // Count value reached on the last differing sample before a commit.
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        STABLE = 1'b0,
        CHECK  = 1'b1
    } state_t;

    // -----------------------------------------------------------------------
    // Synchroniser: free-running, independent of en, so that a re-enable
    // sees an already-settled value of din.
    // -----------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= {SYNC_STAGES{RESET_LEVEL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // -----------------------------------------------------------------------
    // Filter FSM: state register
    // -----------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic            dout_q,  dout_d;
    logic            glitch_q, glitch_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= STABLE;
            cnt_q    <= '0;
            dout_q   <= RESET_LEVEL;
            glitch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            glitch_q <= glitch_d;
        end
    end

    // -----------------------------------------------------------------------
    // Filter FSM: next state / outputs
    // cnt holds the number of consecutive differing samples seen so far in
    // CHECK; it never exceeds DEBOUNCE_CYCLES-1 because the sample that
    // would make it DEBOUNCE_CYCLES commits dout instead.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        glitch_d = 1'b0;

        if (!en) begin
            // Frozen: any candidate in progress is silently dropped, so a
            // later re-enable has to count the full window again.
            state_d = STABLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                STABLE: begin
                    cnt_d = '0;
                    if (s != dout_q) begin
                        if (DEBOUNCE_CYCLES == 1) begin
                            // A single differing sample already satisfies
                            // the window; commit without visiting CHECK.
                            dout_d = s;
                        end else begin
                            state_d = CHECK;
                            cnt_d   = CW'(1);
                        end
                    end
                end

                CHECK: begin
                    if (s == dout_q) begin
                        state_d  = STABLE;
                        cnt_d    = '0;
                        glitch_d = 1'b1;
                    end else if (cnt_q == CNT_LAST) begin
                        dout_d  = s;
                        state_d = STABLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end

                default: begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign dout   = dout_q;
    assign glitch = glitch_q;
    assign busy   = (state_q == CHECK);

endmodule

// File: tb/tb_input_debouncer.sv
// ---------------------------------------------------------------------------
// tb_input_debouncer
//
// Directed bench for input_debouncer (SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// RESET_LEVEL=0). A behavioural model tracks "how many enabled samples in a
// row has the synchronised input disagreed with dout" and predicts dout,
// busy and glitch; a compare process checks all three on every falling
// edge. Directed scenarios additionally pin hand-computed values at known
// edge counts after a stimulus change.
//
// Inputs are driven 1 time unit after the rising edge; "after edge N" below
// means N rising edges after the edge at which the stimulus was applied.
// ---------------------------------------------------------------------------
module tb_input_debouncer;

    localparam int   SYNC_STAGES     = 2;
    localparam int   DEBOUNCE_CYCLES = 4;
    localparam logic RESET_LEVEL     = 1'b0;

    // ---------------- clock / reset ----------------
    logic clk    = 1'b0;
    logic resetn = 1'b1;
    logic en     = 1'b1;
    logic din    = 1'b0;
    logic dout;
    logic busy;
    logic glitch;

    always #5 clk = ~clk;

    input_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .RESET_LEVEL    (RESET_LEVEL)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .en     (en),
        .din    (din),
        .dout   (dout),
        .busy   (busy),
        .glitch (glitch)
    );

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %b expected %b at time %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_hist holds the last SYNC_STAGES samples of din; the oldest entry is
    // what the filter sees at the current edge.
    logic m_hist[$];
    logic m_dout   = RESET_LEVEL;
    logic m_busy   = 1'b0;
    logic m_glitch = 1'b0;
    int   m_run    = 0;
    logic s_seen;
    bit   chk_en   = 1'b0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_hist.delete();
            for (int i = 0; i < SYNC_STAGES; i++) m_hist.push_back(RESET_LEVEL);
            m_dout   = RESET_LEVEL;
            m_run    = 0;
            m_busy   = 1'b0;
            m_glitch = 1'b0;
            chk_en   = 1'b1;
        end else if (chk_en) begin
            s_seen = m_hist.pop_front();
            m_hist.push_back(din);
            m_glitch = 1'b0;
            if (!en) begin
                m_run = 0;
            end else if (s_seen != m_dout) begin
                m_run++;
                if (m_run == DEBOUNCE_CYCLES) begin
                    m_dout = s_seen;
                    m_run  = 0;
                end
            end else begin
                m_glitch = (m_run > 0);
                m_run    = 0;
            end
            m_busy = (m_run > 0);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("model_dout",   dout,   m_dout);
            check("model_busy",   busy,   m_busy);
            check("model_glitch", glitch, m_glitch);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        // 1. Asynchronous reset between edges, no clock needed.
        #1 resetn = 1'b0;
        #1;
        check("rst_dout",   dout,   1'b0);
        check("rst_busy",   busy,   1'b0);
        check("rst_glitch", glitch, 1'b0);
        repeat (2) @(posedge clk);
        #3 resetn = 1'b1;
        tick(6);

        // 2. Clean rising transition: CHECK entered at edge 3, commit at 6.
        din = 1'b1;
        tick(3);
        check("t2_busy_e3", busy, 1'b1);
        check("t2_dout_e3", dout, 1'b0);
        tick(1);
        check("t2_busy_e4", busy, 1'b1);
        tick(1);
        check("t2_busy_e5", busy, 1'b1);
        check("t2_dout_e5", dout, 1'b0);
        tick(1);
        check("t2_dout_e6",   dout,   1'b1);
        check("t2_busy_e6",   busy,   1'b0);
        check("t2_glitch_e6", glitch, 1'b0);
        din = 1'b0;
        tick(8);
        check("t2_fall_done", dout, 1'b0);

        // 3. din high for 3 samples only. The filter sees s=1 at edges 3,4,5
        //    and s=0 at edge 6, so the candidate aborts at edge 6.
        din = 1'b1;
        tick(3);
        din = 1'b0;
        tick(2);
        check("t3_glitch_e5", glitch, 1'b0);
        check("t3_busy_e5",   busy,   1'b1);
        tick(1);
        check("t3_glitch_e6", glitch, 1'b1);
        check("t3_busy_e6",   busy,   1'b0);
        check("t3_dout_e6",   dout,   1'b0);
        tick(1);
        check("t3_glitch_e7", glitch, 1'b0);
        tick(4);

        // 4. din high for exactly 4 samples: rise commits at 6, fall at 10.
        din = 1'b1;
        tick(4);
        din = 1'b0;
        tick(2);
        check("t4_dout_e6", dout, 1'b1);
        tick(3);
        check("t4_dout_e9", dout, 1'b1);
        tick(1);
        check("t4_dout_e10", dout, 1'b0);
        tick(4);

        // 5a. en=0 freezes the filter while the synchroniser keeps running;
        //     re-enable at edge k commits at k+4.
        en  = 1'b0;
        din = 1'b1;
        tick(10);
        check("t5_dout_frozen", dout, 1'b0);
        check("t5_busy_frozen", busy, 1'b0);
        en = 1'b1;
        tick(3);
        check("t5_dout_k3", dout, 1'b0);
        check("t5_busy_k3", busy, 1'b1);
        tick(1);
        check("t5_dout_k4", dout, 1'b1);

        // 5b. en dropped mid-CHECK: candidate dropped, no glitch, full recount.
        din = 1'b0;
        tick(3);
        check("t5b_busy_e3", busy, 1'b1);
        en = 1'b0;
        tick(1);
        check("t5b_busy_off",   busy,   1'b0);
        check("t5b_glitch_off", glitch, 1'b0);
        tick(5);
        check("t5b_dout_held", dout, 1'b1);
        en = 1'b1;
        tick(3);
        check("t5b_dout_k3", dout, 1'b1);
        tick(1);
        check("t5b_dout_k4", dout, 1'b0);
        tick(4);

        // 6. Reset while cnt=2 discards the candidate; after release the
        //    full synchroniser + debounce latency applies again.
        din = 1'b1;
        tick(4);
        check("t6_busy_pre", busy, 1'b1);
        #2 resetn = 1'b0;
        #1;
        check("t6_rst_dout",   dout,   1'b0);
        check("t6_rst_busy",   busy,   1'b0);
        check("t6_rst_glitch", glitch, 1'b0);
        #2 resetn = 1'b1;
        tick(3);
        check("t6_busy_r3", busy, 1'b1);
        tick(2);
        check("t6_dout_r5",   dout,   1'b0);
        check("t6_glitch_r5", glitch, 1'b0);
        tick(1);
        check("t6_dout_r6", dout, 1'b1);
        tick(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
